// File: rtl/morty_wb_arbiter.sv
// rtl/morty_wb_arbiter.sv - two-master to one-slave Wishbone classic arbiter
module morty_wb_arbiter #(
   parameter int unsigned TIMEOUT   = 0,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // instruction master
   input  logic [31:0] iwbm_addr_i,
   input  logic        iwbm_cyc_i,
   input  logic        iwbm_stb_i,
   output logic [31:0] iwbm_dat_o,
   output logic        iwbm_ack_o,
   output logic        iwbm_err_o,
   // data master
   input  logic [31:0] dwbm_addr_i,
   input  logic [31:0] dwbm_dat_i,
   input  logic [3:0]  dwbm_sel_i,
   input  logic        dwbm_we_i,
   input  logic        dwbm_cyc_i,
   input  logic        dwbm_stb_i,
   output logic [31:0] dwbm_dat_o,
   output logic        dwbm_ack_o,
   output logic        dwbm_err_o,
   // shared slave
   output logic [31:0] wbs_addr_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  wbs_sel_o,
   output logic        wbs_we_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   input  logic [31:0] wbs_dat_i,
   input  logic        wbs_ack_i,
   input  logic        wbs_err_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   // Watchdog fires on the cycle where the counter reaches TIMEOUT-1.
   localparam logic                 WD_EN   = (TIMEOUT > 0);
   localparam logic [TIMEOUT_W-1:0] WD_LAST = (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : '0;

   state_e               state_q, state_d;
   logic                 last_d_q, last_d_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;

   logic req_i, req_d;
   logic gnt_cyc, timeout_hit, done_ack, done_err;

   assign req_i = iwbm_cyc_i & iwbm_stb_i;
   assign req_d = dwbm_cyc_i & dwbm_stb_i;

   // Read data is broadcast; only the ack tells a master it is valid.
   assign iwbm_dat_o = wbs_dat_i;
   assign dwbm_dat_o = wbs_dat_i;

   // Arbitration, slave muxing, completion and watchdog next-state logic.
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      wd_d        = wd_q;
      gnt_cyc     = 1'b0;
      timeout_hit = 1'b0;
      done_ack    = 1'b0;
      done_err    = 1'b0;
      wbs_addr_o  = '0;
      wbs_dat_o   = '0;
      wbs_sel_o   = '0;
      wbs_we_o    = 1'b0;
      wbs_cyc_o   = 1'b0;
      wbs_stb_o   = 1'b0;
      iwbm_ack_o  = 1'b0;
      iwbm_err_o  = 1'b0;
      dwbm_ack_o  = 1'b0;
      dwbm_err_o  = 1'b0;

      case (state_q)
         IDLE: begin
            // Counter is cleared here so every BUSY entry starts from zero.
            wd_d = '0;
            if (req_i && req_d) begin
               if (last_d_q) begin
                  state_d  = BUSY_I;
                  last_d_d = 1'b0;
               end else begin
                  state_d  = BUSY_D;
                  last_d_d = 1'b1;
               end
            end else if (req_d) begin
               state_d  = BUSY_D;
               last_d_d = 1'b1;
            end else if (req_i) begin
               state_d  = BUSY_I;
               last_d_d = 1'b0;
            end
         end

         BUSY_I, BUSY_D: begin
            if (state_q == BUSY_D) begin
               gnt_cyc    = dwbm_cyc_i;
               wbs_addr_o = dwbm_addr_i;
               wbs_dat_o  = dwbm_dat_i;
               wbs_sel_o  = dwbm_sel_i;
               wbs_we_o   = dwbm_we_i;
            end else begin
               gnt_cyc    = iwbm_cyc_i;
               wbs_addr_o = iwbm_addr_i;
               wbs_sel_o  = 4'hF;
            end
            // A master dropping cyc kills the slave cycle immediately.
            wbs_cyc_o = gnt_cyc;
            wbs_stb_o = gnt_cyc;

            timeout_hit = WD_EN && (wd_q == WD_LAST) && !wbs_ack_i && !wbs_err_i;
            done_err    = gnt_cyc && (wbs_err_i || timeout_hit);
            done_ack    = gnt_cyc && wbs_ack_i && !wbs_err_i;

            if (state_q == BUSY_D) begin
               dwbm_ack_o = done_ack;
               dwbm_err_o = done_err;
            end else begin
               iwbm_ack_o = done_ack;
               iwbm_err_o = done_err;
            end

            if (!gnt_cyc || done_ack || done_err) begin
               state_d = IDLE;
            end else if (wd_q != '1) begin
               wd_d = wd_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State, fairness bit and watchdog counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         wd_q     <= wd_d;
      end
   end

endmodule

// File: tb/tb_morty_wb_arbiter.sv
// tb/tb_morty_wb_arbiter.sv - self-checking bench for morty_wb_arbiter
module tb_morty_wb_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] iaddr, daddr, ddat, sdat;
   logic [3:0]  dsel;
   logic        icyc, istb, dcyc, dstb, dwe, sack, serr;
   logic [31:0] idat_o, ddat_o, wbs_addr, wbs_dat;
   logic [3:0]  wbs_sel;
   logic        iack, ierr, dack, derr, wbs_we, wbs_cyc, wbs_stb;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the bus (0 none, 1 instruction, 2 data),
   // who won the last grant, and how many silent BUSY cycles have elapsed.
   int          m_own;
   bit          m_lastd;
   int          m_wd;
   logic [31:0] e_addr, e_wdat;
   logic [3:0]  e_sel;
   logic        e_we, e_cyc, e_iack, e_ierr, e_dack, e_derr;

   always #5 clk = ~clk;

   morty_wb_arbiter #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .iwbm_addr_i(iaddr), .iwbm_cyc_i(icyc), .iwbm_stb_i(istb),
      .iwbm_dat_o(idat_o), .iwbm_ack_o(iack), .iwbm_err_o(ierr),
      .dwbm_addr_i(daddr), .dwbm_dat_i(ddat), .dwbm_sel_i(dsel), .dwbm_we_i(dwe),
      .dwbm_cyc_i(dcyc), .dwbm_stb_i(dstb),
      .dwbm_dat_o(ddat_o), .dwbm_ack_o(dack), .dwbm_err_o(derr),
      .wbs_addr_o(wbs_addr), .wbs_dat_o(wbs_dat), .wbs_sel_o(wbs_sel), .wbs_we_o(wbs_we),
      .wbs_cyc_o(wbs_cyc), .wbs_stb_o(wbs_stb),
      .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outputs the model expects for the current inputs and model state.
   task automatic expect_outputs();
      bit c;
      bit fin_err, fin_ack;
      e_addr = '0; e_wdat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0;
      e_iack = 1'b0; e_ierr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
      if (m_own != 0) begin
         c       = (m_own == 2) ? dcyc : icyc;
         e_cyc   = c;
         fin_err = c && (serr || (!sack && m_wd == TO - 1));
         fin_ack = c && sack && !serr;
         if (m_own == 2) begin
            e_addr = daddr; e_wdat = ddat; e_sel = dsel; e_we = dwe;
            e_dack = fin_ack; e_derr = fin_err;
         end else begin
            e_addr = iaddr; e_sel = 4'hF;
            e_iack = fin_ack; e_ierr = fin_err;
         end
      end
   endtask

   // Advance the model across one clock edge using the inputs held before it.
   task automatic model_update();
      bit ri, rd;
      if (rst) begin
         m_own = 0; m_lastd = 1'b0; m_wd = 0;
      end else if (m_own == 0) begin
         ri = icyc & istb;
         rd = dcyc & dstb;
         if (ri && rd) m_own = m_lastd ? 1 : 2;
         else if (rd)  m_own = 2;
         else if (ri)  m_own = 1;
         if (m_own != 0) m_lastd = (m_own == 2);
         m_wd = 0;
      end else begin
         expect_outputs();
         if (!e_cyc || e_iack || e_ierr || e_dack || e_derr) m_own = 0;
         else if (m_wd < 255) m_wd = m_wd + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic settle();
      #2;
      expect_outputs();
      chk("wbs_cyc", wbs_cyc, e_cyc);
      chk("wbs_stb", wbs_stb, e_cyc);
      chk("wbs_addr", wbs_addr, e_addr);
      chk("wbs_dat", wbs_dat, e_wdat);
      chk("wbs_sel", wbs_sel, e_sel);
      chk("wbs_we", wbs_we, e_we);
      chk("iack", iack, e_iack);
      chk("ierr", ierr, e_ierr);
      chk("dack", dack, e_dack);
      chk("derr", derr, e_derr);
      chk("idat", idat_o, sdat);
      chk("ddat", ddat_o, sdat);
   endtask

   initial begin
      m_own = 0; m_lastd = 1'b0; m_wd = 0;
      rst = 1'b1; icyc = 0; istb = 0; dcyc = 0; dstb = 0; dwe = 0;
      iaddr = '0; daddr = '0; ddat = '0; dsel = '0; sdat = 32'h1234_5678; sack = 0; serr = 0;

      // Reset state
      tick(); tick(); settle();
      chk("rst_cyc", wbs_cyc, 1'b0);
      chk("rst_dack", dack, 1'b0);
      rst = 1'b0;

      // Single data write, slave acks two cycles into the transfer
      tick(); dcyc = 1; dstb = 1; dwe = 1; daddr = 32'h100; ddat = 32'hDEAD_BEEF; dsel = 4'hF; settle();
      chk("wr_idle_cyc", wbs_cyc, 1'b0);
      tick(); settle();
      chk("wr_cyc", wbs_cyc, 1'b1);
      chk("wr_we", wbs_we, 1'b1);
      chk("wr_addr", wbs_addr, 32'h100);
      chk("wr_dat", wbs_dat, 32'hDEAD_BEEF);
      tick(); settle();
      chk("wr_wait_dack", dack, 1'b0);
      tick(); sack = 1; settle();
      chk("wr_dack", dack, 1'b1);
      chk("wr_iack", iack, 1'b0);
      tick(); dcyc = 0; dstb = 0; dwe = 0; sack = 0; settle();
      chk("wr_after_dack", dack, 1'b0);

      // Tie held from reset, slave acks at once: order D,I,D,I with idle gaps
      tick(); rst = 1; icyc = 1; istb = 1; iaddr = 32'h0; dcyc = 1; dstb = 1; daddr = 32'h200; sack = 1; settle();
      tick(); rst = 0; settle();
      chk("rr_0_idle", wbs_cyc, 1'b0);
      for (int k = 1; k < 8; k++) begin
         tick(); settle();
         if (k % 2 == 0) chk("rr_idle", wbs_cyc, 1'b0);
         else begin
            chk("rr_addr", wbs_addr, (k % 4 == 1) ? 32'h200 : 32'h0);
            chk("rr_ack", {30'b0, iack, dack}, (k % 4 == 1) ? 32'd1 : 32'd2);
         end
      end
      tick(); icyc = 0; istb = 0; dcyc = 0; dstb = 0; sack = 0; settle();

      // Instruction fetch aborted while a data request waits
      tick(); icyc = 1; istb = 1; iaddr = 32'h40; settle();
      tick(); dcyc = 1; dstb = 1; daddr = 32'h300; dwe = 0; settle();
      chk("ab_busy_addr", wbs_addr, 32'h40);
      chk("ab_busy_sel", wbs_sel, 4'hF);
      tick(); icyc = 0; istb = 0; sack = 1; settle();
      chk("ab_cyc", wbs_cyc, 1'b0);
      chk("ab_iack", iack, 1'b0);
      tick(); sack = 0; settle();
      chk("ab_idle", wbs_cyc, 1'b0);
      tick(); settle();
      chk("ab_d_cyc", wbs_cyc, 1'b1);
      chk("ab_d_addr", wbs_addr, 32'h300);
      tick(); sack = 1; settle();
      chk("ab_d_ack", dack, 1'b1);
      tick(); dcyc = 0; dstb = 0; sack = 0; settle();

      // Slave error with simultaneous ack: error wins
      tick(); dcyc = 1; dstb = 1; settle();
      tick(); sack = 1; serr = 1; settle();
      chk("err_derr", derr, 1'b1);
      chk("err_dack", dack, 1'b0);
      tick(); dcyc = 0; dstb = 0; sack = 0; serr = 0; settle();
      chk("err_idle", wbs_cyc, 1'b0);

      // Silent slave: watchdog error on 4th BUSY cycle, cyc low on 5th
      tick(); dcyc = 1; dstb = 1; settle();
      for (int k = 1; k <= 4; k++) begin
         tick(); settle();
         chk("wd_cyc", wbs_cyc, 1'b1);
         chk("wd_derr", derr, (k == 4) ? 1'b1 : 1'b0);
      end
      tick(); dcyc = 0; dstb = 0; settle();
      chk("wd_5_cyc", wbs_cyc, 1'b0);

      // Reset during BUSY_I, then a tie goes to data
      tick(); icyc = 1; istb = 1; iaddr = 32'h44; settle();
      tick(); settle();
      chk("rb_busy", wbs_cyc, 1'b1);
      rst = 1; dcyc = 1; dstb = 1; daddr = 32'h500;
      tick(); settle();
      chk("rb_cyc", wbs_cyc, 1'b0);
      chk("rb_iack", iack, 1'b0);
      tick(); rst = 0; settle();
      tick(); settle();
      chk("rb_tie_addr", wbs_addr, 32'h500);
      tick(); icyc = 0; istb = 0; dcyc = 0; dstb = 0; settle();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         tick();
         if (icyc && (e_iack || e_ierr)) icyc = 0;
         else if (icyc && $urandom_range(15) == 0) icyc = 0;
         else if (!icyc && $urandom_range(1) == 1) begin icyc = 1; iaddr = $urandom; end
         istb = icyc;
         if (dcyc && (e_dack || e_derr)) dcyc = 0;
         else if (dcyc && $urandom_range(15) == 0) dcyc = 0;
         else if (!dcyc && $urandom_range(1) == 1) begin
            dcyc = 1; daddr = $urandom; ddat = $urandom; dsel = 4'($urandom); dwe = 1'($urandom);
         end
         dstb = dcyc;
         sack = ($urandom_range(2) == 0);
         serr = ($urandom_range(7) == 0);
         sdat = $urandom;
         rst  = ($urandom_range(63) == 0);
         settle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
